// File: rtl/eeg_fram_seq_if.sv
// Bundle of the task-descriptor handshake and the FRAM CFG_INFO/IS_IDLE signals.
// slave  : the sequencer side (takes descriptors, drives FRAM commands).
// master : the task-controller / FRAM side.
interface eeg_fram_seq_if #(
    parameter int FRAM_CMD_DW  = 4,
    parameter int LAYER_NUM_DW = 4,
    parameter int TIMEOUT_DW   = 16
);
    logic                    TASK_VLD;
    logic                    TASK_RDY;
    logic [LAYER_NUM_DW-1:0] TASK_LAYER_NUM;
    logic                    TASK_OTOF_ENA;
    logic                    TASK_FLAG_VLD;
    logic [TIMEOUT_DW-1:0]   TASK_TIMEOUT;
    logic                    CFG_INFO_VLD;
    logic                    CFG_INFO_RDY;
    logic [FRAM_CMD_DW-1:0]  CFG_INFO_CMD;
    logic                    CFG_FLAG_VLD;
    logic                    FRAM_IS_IDLE;
    logic                    SEQ_BUSY;
    logic                    SEQ_DONE;
    logic                    SEQ_ERR;
    logic [LAYER_NUM_DW-1:0] SEQ_LAYER_CNT;

    modport slave (
        input  TASK_VLD, TASK_LAYER_NUM, TASK_OTOF_ENA, TASK_FLAG_VLD, TASK_TIMEOUT,
        input  CFG_INFO_RDY, FRAM_IS_IDLE,
        output TASK_RDY, CFG_INFO_VLD, CFG_INFO_CMD, CFG_FLAG_VLD,
        output SEQ_BUSY, SEQ_DONE, SEQ_ERR, SEQ_LAYER_CNT
    );

    modport master (
        output TASK_VLD, TASK_LAYER_NUM, TASK_OTOF_ENA, TASK_FLAG_VLD, TASK_TIMEOUT,
        output CFG_INFO_RDY, FRAM_IS_IDLE,
        input  TASK_RDY, CFG_INFO_VLD, CFG_INFO_CMD, CFG_FLAG_VLD,
        input  SEQ_BUSY, SEQ_DONE, SEQ_ERR, SEQ_LAYER_CNT
    );
endinterface

// File: rtl/eeg_fram_seq.sv
// FRAM command sequencer: for one task descriptor issues ITOF, CONV x LAYER_NUM and an
// optional OTOF, waiting for the FRAM to go idle after each command. A per-command wait
// timeout aborts the chain with a sticky error flag.
module eeg_fram_seq #(
    parameter int FRAM_CMD_DW  = 4,
    parameter int LAYER_NUM_DW = 4,
    parameter int TIMEOUT_DW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    eeg_fram_seq_if.slave  bus
);
    localparam logic [FRAM_CMD_DW-1:0] CMD_IDLE = FRAM_CMD_DW'(4'b0001);
    localparam logic [FRAM_CMD_DW-1:0] CMD_ITOF = FRAM_CMD_DW'(4'b0010);
    localparam logic [FRAM_CMD_DW-1:0] CMD_CONV = FRAM_CMD_DW'(4'b0100);
    localparam logic [FRAM_CMD_DW-1:0] CMD_OTOF = FRAM_CMD_DW'(4'b1000);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                  state_reg;
    logic [LAYER_NUM_DW-1:0] layer_num_reg;
    logic                    otof_ena_reg;
    logic                    flag_reg;
    logic [TIMEOUT_DW-1:0]   timeout_reg;
    logic [TIMEOUT_DW-1:0]   wait_cnt_reg;

    logic                    task_rdy_reg;
    logic                    cfg_vld_reg;
    logic [FRAM_CMD_DW-1:0]  cfg_cmd_reg;
    logic                    cfg_flag_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [LAYER_NUM_DW-1:0] layer_cnt_reg;

    // The counter is 0 only in the first WAIT cycle (it saturates, never wraps back),
    // which is exactly the cycle where FRAM_IS_IDLE is still stale and must be ignored.
    logic                    wait_first;
    logic                    cmd_complete;
    logic                    timeout_hit;
    logic [LAYER_NUM_DW:0]   layer_next;
    logic                    more_conv;
    logic [FRAM_CMD_DW-1:0]  next_cmd;
    logic                    chain_end;

    assign wait_first   = (wait_cnt_reg == '0);
    assign cmd_complete = !wait_first && bus.FRAM_IS_IDLE;
    assign timeout_hit  = (timeout_reg != '0) && (wait_cnt_reg == timeout_reg - TIMEOUT_DW'(1));
    // One extra bit so LAYER_NUM = max still compares correctly.
    assign layer_next   = {1'b0, layer_cnt_reg} + (LAYER_NUM_DW+1)'(1);
    assign more_conv    = layer_next < {1'b0, layer_num_reg};

    // Choose the command that follows the one just completed, or flag end of chain.
    always_comb begin
        next_cmd  = CMD_OTOF;
        chain_end = 1'b0;
        if (cfg_cmd_reg == CMD_ITOF) begin
            if (layer_num_reg != '0)  next_cmd = CMD_CONV;
            else if (!otof_ena_reg)   chain_end = 1'b1;
        end else if (cfg_cmd_reg == CMD_CONV) begin
            if (more_conv)            next_cmd = CMD_CONV;
            else if (!otof_ena_reg)   chain_end = 1'b1;
        end else begin
            chain_end = 1'b1;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            layer_num_reg <= '0;
            otof_ena_reg  <= 1'b0;
            flag_reg      <= 1'b0;
            timeout_reg   <= '0;
            wait_cnt_reg  <= '0;
            task_rdy_reg  <= 1'b1;
            cfg_vld_reg   <= 1'b0;
            cfg_cmd_reg   <= CMD_IDLE;
            cfg_flag_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            layer_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.TASK_VLD && task_rdy_reg) begin
                        layer_num_reg <= bus.TASK_LAYER_NUM;
                        otof_ena_reg  <= bus.TASK_OTOF_ENA;
                        flag_reg      <= bus.TASK_FLAG_VLD;
                        timeout_reg   <= bus.TASK_TIMEOUT;
                        err_reg       <= 1'b0;
                        layer_cnt_reg <= '0;
                        task_rdy_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                        cfg_cmd_reg   <= CMD_ITOF;
                        cfg_flag_reg  <= bus.TASK_FLAG_VLD;
                        cfg_vld_reg   <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // No timeout here: a stalled FRAM ready simply holds the command.
                    if (bus.CFG_INFO_RDY) begin
                        cfg_vld_reg  <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg != '1) begin
                        wait_cnt_reg <= wait_cnt_reg + TIMEOUT_DW'(1);
                    end
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (cmd_complete) begin
                        if (cfg_cmd_reg == CMD_CONV) begin
                            layer_cnt_reg <= layer_next[LAYER_NUM_DW-1:0];
                        end
                        if (chain_end) begin
                            cfg_cmd_reg  <= CMD_IDLE;
                            cfg_flag_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            cfg_cmd_reg  <= next_cmd;
                            cfg_flag_reg <= (next_cmd == CMD_OTOF) ? 1'b1 : flag_reg;
                            cfg_vld_reg  <= 1'b1;
                            state_reg    <= ST_ISSUE;
                        end
                    end else if (timeout_hit) begin
                        err_reg      <= 1'b1;
                        cfg_cmd_reg  <= CMD_IDLE;
                        cfg_flag_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        task_rdy_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    task_rdy_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.TASK_RDY      = task_rdy_reg;
    assign bus.CFG_INFO_VLD  = cfg_vld_reg;
    assign bus.CFG_INFO_CMD  = cfg_cmd_reg;
    assign bus.CFG_FLAG_VLD  = cfg_flag_reg;
    assign bus.SEQ_BUSY      = busy_reg;
    assign bus.SEQ_DONE      = done_reg;
    assign bus.SEQ_ERR       = err_reg;
    assign bus.SEQ_LAYER_CNT = layer_cnt_reg;

endmodule

// File: tb/tb_eeg_fram_seq.sv
// Directed bench for eeg_fram_seq: a small FRAM model that goes busy after every command
// handshake and logs the command stream; each scenario task checks its own results.
module tb_eeg_fram_seq;
    logic clk;
    logic rst;

    eeg_fram_seq_if #(.FRAM_CMD_DW(4), .LAYER_NUM_DW(4), .TIMEOUT_DW(16)) bus ();

    eeg_fram_seq #(.FRAM_CMD_DW(4), .LAYER_NUM_DW(4), .TIMEOUT_DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total;
    int bad;
    int done_cnt;

    // FRAM model controls
    int   fram_lat;
    bit   hang_conv;
    bit   kick;
    logic fram_idle;
    int   busy_left;

    logic [3:0] cmd_q[$];
    bit         flag_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.FRAM_IS_IDLE = fram_idle;

    // FRAM model: leaves idle on each handshake, returns fram_lat clocks later (or never).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fram_idle <= 1'b1;
            busy_left <= 0;
        end else if (kick) begin
            fram_idle <= 1'b1;
            busy_left <= 0;
        end else if (bus.CFG_INFO_VLD && bus.CFG_INFO_RDY) begin
            fram_idle <= 1'b0;
            busy_left <= (hang_conv && bus.CFG_INFO_CMD == 4'b0100) ? 0 : fram_lat;
        end else if (busy_left == 1) begin
            fram_idle <= 1'b1;
            busy_left <= 0;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end
    end

    // Command log and completion-pulse counter.
    always @(posedge clk) begin
        if (!rst && bus.CFG_INFO_VLD && bus.CFG_INFO_RDY) begin
            cmd_q.push_back(bus.CFG_INFO_CMD);
            flag_q.push_back(bus.CFG_FLAG_VLD);
        end
        if (!rst && bus.SEQ_DONE) done_cnt = done_cnt + 1;
    end

    task automatic run_task(input logic [3:0] ln, input bit otof, input bit flag,
                            input logic [15:0] tmo, output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.TASK_RDY !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        ok = (bus.TASK_RDY === 1'b1);
        bus.TASK_LAYER_NUM = ln;
        bus.TASK_OTOF_ENA  = otof;
        bus.TASK_FLAG_VLD  = flag;
        bus.TASK_TIMEOUT   = tmo;
        bus.TASK_VLD       = ok;
        @(negedge clk);
        bus.TASK_VLD = 1'b0;
        $display("task layer=%0d otof=%0d flag=%0d timeout=%0d accepted=%0d", ln, otof, flag, tmo, ok);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cnt != start);
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (cmd_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (cmd_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.TASK_RDY !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.TASK_RDY); end
        total++; if (bus.CFG_INFO_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", bus.CFG_INFO_VLD); end
        total++; if (bus.CFG_INFO_CMD !== 4'b0001) begin bad++; $display("FAIL reset_cmd got=%b exp=0001", bus.CFG_INFO_CMD); end
        total++; if ({bus.CFG_FLAG_VLD, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.CFG_FLAG_VLD, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR}); end
        total++; if (bus.SEQ_LAYER_CNT !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.SEQ_LAYER_CNT); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_chain();
        logic [3:0] exp_cmd [5];
        bit ok;
        int d0;
        exp_cmd = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        cmd_q.delete(); flag_q.delete();
        fram_lat = 5;
        d0 = done_cnt;
        run_task(4'd3, 1'b1, 1'b1, 16'd0, ok);
        wait_done(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL chain_done_timeout got=none exp=pulse"); end
        repeat (3) @(negedge clk);
        total++; if (cmd_q.size() != 5) begin bad++; $display("FAIL chain_len got=%0d exp=5", cmd_q.size()); end
        for (int i = 0; i < 5 && i < cmd_q.size(); i++) begin
            total++; if (cmd_q[i] !== exp_cmd[i]) begin bad++; $display("FAIL chain_cmd%0d got=%b exp=%b", i, cmd_q[i], exp_cmd[i]); end
            total++; if (flag_q[i] !== 1'b1) begin bad++; $display("FAIL chain_flag%0d got=%b exp=1", i, flag_q[i]); end
        end
        total++; if (bus.SEQ_LAYER_CNT !== 4'd3) begin bad++; $display("FAIL chain_cnt got=%0d exp=3", bus.SEQ_LAYER_CNT); end
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL chain_pulses got=%0d exp=1", done_cnt - d0); end
        total++; if (bus.SEQ_BUSY !== 1'b0 || bus.TASK_RDY !== 1'b1) begin
            bad++; $display("FAIL chain_idle got=busy%b rdy%b exp=busy0 rdy1", bus.SEQ_BUSY, bus.TASK_RDY); end
    endtask

    task automatic test_itof_only();
        bit ok;
        int k;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 5;
        run_task(4'd0, 1'b0, 1'b1, 16'd0, ok);
        wait_log(1, 50, ok);
        k = 0;
        while (fram_idle !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        total++; if (bus.SEQ_DONE !== 1'b0) begin bad++; $display("FAIL itof_done_early got=%b exp=0", bus.SEQ_DONE); end
        @(negedge clk);
        total++; if (bus.SEQ_DONE !== 1'b1) begin bad++; $display("FAIL itof_done_latency got=%b exp=1", bus.SEQ_DONE); end
        @(negedge clk);
        total++; if (bus.SEQ_DONE !== 1'b0 || bus.TASK_RDY !== 1'b1) begin
            bad++; $display("FAIL itof_after got=done%b rdy%b exp=done0 rdy1", bus.SEQ_DONE, bus.TASK_RDY); end
        total++; if (cmd_q.size() != 1 || cmd_q[0] !== 4'b0010) begin
            bad++; $display("FAIL itof_cmds got=n%0d exp=n1 ITOF", cmd_q.size()); end
        total++; if (bus.SEQ_LAYER_CNT !== 4'd0) begin bad++; $display("FAIL itof_cnt got=%0d exp=0", bus.SEQ_LAYER_CNT); end
    endtask

    task automatic test_flag_zero();
        bit ok;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 3;
        run_task(4'd1, 1'b1, 1'b0, 16'd0, ok);
        wait_done(300, ok);
        total++; if (!ok || cmd_q.size() != 3) begin bad++; $display("FAIL flag_len got=%0d exp=3", cmd_q.size()); end
        if (cmd_q.size() == 3) begin
            total++; if ({cmd_q[0], cmd_q[1], cmd_q[2]} !== 12'b0010_0100_1000) begin
                bad++; $display("FAIL flag_cmds got=%b %b %b exp=0010 0100 1000", cmd_q[0], cmd_q[1], cmd_q[2]); end
            total++; if ({flag_q[0], flag_q[1], flag_q[2]} !== 3'b001) begin
                bad++; $display("FAIL flag_vals got=%b%b%b exp=001", flag_q[0], flag_q[1], flag_q[2]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int d0;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 5;
        hang_conv = 1'b1;
        d0 = done_cnt;
        run_task(4'd2, 1'b1, 1'b1, 16'd10, ok);
        wait_log(2, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_conv_issue got=n%0d exp=n2", cmd_q.size()); end
        n = 0;
        while (bus.SEQ_BUSY === 1'b1 && n < 100) begin n++; @(negedge clk); end
        total++; if (n != 10) begin bad++; $display("FAIL tmo_wait_cycles got=%0d exp=10", n); end
        total++; if (bus.SEQ_ERR !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", bus.SEQ_ERR); end
        total++; if (bus.TASK_RDY !== 1'b1) begin bad++; $display("FAIL tmo_idle got=%b exp=1", bus.TASK_RDY); end
        repeat (2) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL tmo_no_done got=%0d exp=0", done_cnt - d0); end
        total++; if (bus.SEQ_ERR !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky got=%b exp=1", bus.SEQ_ERR); end
        hang_conv = 1'b0;
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        run_task(4'd0, 1'b0, 1'b1, 16'd10, ok);
        total++; if (bus.SEQ_ERR !== 1'b0) begin bad++; $display("FAIL tmo_err_clear got=%b exp=0", bus.SEQ_ERR); end
        wait_done(100, ok);
        total++; if (!ok || bus.SEQ_ERR !== 1'b0) begin bad++; $display("FAIL tmo_recover got=done%0d err%b exp=done1 err0", ok, bus.SEQ_ERR); end
    endtask

    task automatic test_stall();
        bit ok;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 2;
        bus.CFG_INFO_RDY = 1'b0;
        run_task(4'd0, 1'b0, 1'b1, 16'd3, ok);
        for (int i = 0; i < 7; i++) begin
            total++; if (bus.CFG_INFO_VLD !== 1'b1 || bus.CFG_INFO_CMD !== 4'b0010) begin
                bad++; $display("FAIL stall_hold%0d got=vld%b cmd%b exp=vld1 cmd0010", i, bus.CFG_INFO_VLD, bus.CFG_INFO_CMD); end
            @(negedge clk);
        end
        total++; if (bus.SEQ_ERR !== 1'b0) begin bad++; $display("FAIL stall_no_err got=%b exp=0", bus.SEQ_ERR); end
        bus.CFG_INFO_RDY = 1'b1;
        wait_done(100, ok);
        total++; if (!ok || cmd_q.size() != 1) begin bad++; $display("FAIL stall_handshakes got=%0d exp=1", cmd_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 5;
        run_task(4'd3, 1'b0, 1'b1, 16'd0, ok);
        wait_log(3, 100, ok);
        @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        total++; if (bus.CFG_INFO_VLD !== 1'b0 || bus.TASK_RDY !== 1'b1 || bus.CFG_INFO_CMD !== 4'b0001) begin
            bad++; $display("FAIL rstmid_bus got=vld%b rdy%b cmd%b exp=vld0 rdy1 cmd0001", bus.CFG_INFO_VLD, bus.TASK_RDY, bus.CFG_INFO_CMD); end
        total++; if ({bus.CFG_FLAG_VLD, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR} !== 4'b0000 || bus.SEQ_LAYER_CNT !== 4'd0) begin
            bad++; $display("FAIL rstmid_status got=%b cnt%0d exp=0000 cnt0", {bus.CFG_FLAG_VLD, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR}, bus.SEQ_LAYER_CNT); end
        @(negedge clk);
        rst = 1'b0;
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - d0); end
        cmd_q.delete(); flag_q.delete();
        run_task(4'd1, 1'b1, 1'b1, 16'd0, ok);
        wait_done(300, ok);
        total++; if (!ok || cmd_q.size() != 3) begin bad++; $display("FAIL rstmid_rerun_len got=%0d exp=3", cmd_q.size()); end
        if (cmd_q.size() == 3) begin
            total++; if ({cmd_q[0], cmd_q[1], cmd_q[2]} !== 12'b0010_0100_1000) begin
                bad++; $display("FAIL rstmid_rerun_cmds got=%b %b %b exp=0010 0100 1000", cmd_q[0], cmd_q[1], cmd_q[2]); end
        end
    endtask

    task automatic test_max_layers();
        bit ok;
        cmd_q.delete(); flag_q.delete();
        fram_lat = 1;
        run_task(4'd15, 1'b0, 1'b0, 16'd0, ok);
        wait_done(1000, ok);
        total++; if (!ok || cmd_q.size() != 16) begin bad++; $display("FAIL max_len got=%0d exp=16", cmd_q.size()); end
        total++; if (bus.SEQ_LAYER_CNT !== 4'd15) begin bad++; $display("FAIL max_cnt got=%0d exp=15", bus.SEQ_LAYER_CNT); end
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        fram_lat = 5; hang_conv = 1'b0; kick = 1'b0;
        rst = 1'b1;
        bus.TASK_VLD = 1'b0; bus.TASK_LAYER_NUM = '0; bus.TASK_OTOF_ENA = 1'b0;
        bus.TASK_FLAG_VLD = 1'b0; bus.TASK_TIMEOUT = '0; bus.CFG_INFO_RDY = 1'b1;
        test_reset();
        test_full_chain();
        test_itof_only();
        test_flag_zero();
        test_timeout();
        test_stall();
        test_reset_mid();
        test_max_layers();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
